// File: rtl/dec8_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec8_disp_pkg
// Brief    : Shared constants and BCD-to-7-segment pattern function for the
//            8-digit scanned display.
// Revision : 1.0  initial release
// ============================================================================
package dec8_disp_pkg;

    localparam int NDIG = 8;

    typedef logic [6:0] seg_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam seg_t SEG_0 = 7'h40;
    localparam seg_t SEG_1 = 7'h79;
    localparam seg_t SEG_2 = 7'h24;
    localparam seg_t SEG_3 = 7'h30;
    localparam seg_t SEG_4 = 7'h19;
    localparam seg_t SEG_5 = 7'h12;
    localparam seg_t SEG_6 = 7'h02;
    localparam seg_t SEG_7 = 7'h78;
    localparam seg_t SEG_8 = 7'h00;
    localparam seg_t SEG_9 = 7'h10;

    function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
        seg_t s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec8_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module   : dec8_scan_display_if
// Brief    : Data/strobe inputs and display pin outputs of the scanned display.
// Revision : 1.0  initial release
// ============================================================================
interface dec8_scan_display_if;

    logic [31:0] DEC;
    logic        ld;
    logic        blank_lz;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    modport master (
        output DEC,
        output ld,
        output blank_lz,
        input  AN,
        input  SEG,
        input  DP
    );

    modport slave (
        input  DEC,
        input  ld,
        input  blank_lz,
        output AN,
        output SEG,
        output DP
    );

endinterface
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Brief    : Combinational BCD nibble to active-low 7-segment pattern.
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_seg7
    import dec8_disp_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output seg_t            o_seg
);

    assign o_seg = bcd_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/dec8_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : dec8_scan_display
// Brief    : Latches a packed 8-digit BCD word and scans it onto a multiplexed
//            common-anode display with zero blanking, guard time and DP.
// Revision : 1.0  initial release
// ============================================================================
module dec8_scan_display
    import dec8_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2,
    parameter int DP_POS   = 8
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    dec8_scan_display_if.slave bus
);

    localparam int          c_PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [31:0] c_GUARD = GUARD;
    localparam logic [3:0]  c_DP    = 4'(DP_POS);

    logic [c_PW-1:0] r_presc;
    logic [2:0]      r_ptr;
    logic [31:0]     r_disp;
    logic [7:0]      r_an;
    seg_t            r_seg;
    logic            r_dp;

    logic            w_tick;
    logic            w_guard;
    logic            w_blank;
    logic            w_dp_hit;
    logic            w_acc;
    logic [3:0]      w_nib;
    logic [NDIG-1:0] w_zfrom;
    seg_t            w_seg_raw;

    assign w_tick   = (r_presc == c_PW'(SCAN_DIV - 1));
    assign w_guard  = ({{(32-c_PW){1'b0}}, r_presc} < c_GUARD);
    assign w_dp_hit = ({1'b0, r_ptr} == c_DP);
    assign w_nib    = r_disp[4*r_ptr +: 4];

    // w_zfrom[i] is set when every nibble from the top down to i is zero.
    always_comb begin
        w_acc   = 1'b1;
        w_zfrom = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_acc      = w_acc & (r_disp[4*i +: 4] == 4'd0);
            w_zfrom[i] = w_acc;
        end
    end

    assign w_blank = bus.blank_lz && (r_ptr != 3'd0) && w_zfrom[r_ptr];

    bcd_to_seg7 u_seg (
        .i_nibble (w_nib),
        .o_seg    (w_seg_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ptr   <= 3'd0;
            r_disp  <= '0;
            r_an    <= 8'hFF;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_ptr <= r_ptr + 3'd1;
            if (bus.ld)
                r_disp <= bus.DEC;

            if (w_guard) begin
                r_an  <= 8'hFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(8'b1 << r_ptr);
                r_seg <= w_blank ? SEG_BLANK : w_seg_raw;
                r_dp  <= ~w_dp_hit;
            end
        end
    end

    assign bus.AN  = r_an;
    assign bus.SEG = r_seg;
    assign bus.DP  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_dec8_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec8_scan_display
// Brief    : Directed self-checking bench for dec8_scan_display.
// Revision : 1.0  initial release
// ============================================================================
module tb_dec8_scan_display;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    dec8_scan_display_if bus_if ();

    dec8_scan_display #(
        .SCAN_DIV (4),
        .GUARD    (1),
        .DP_POS   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Advance until the outputs show slot d, phase ph (phase 0 = guard).
    task automatic goto(input int d, input int ph);
        bit found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (((cyc - 1) % 4) == ph && (((cyc - 1) / 4) % 8) == d) begin
                found = 1'b1;
                break;
            end
        end
        chk("goto_bound", 32'(found), 32'd1);
    endtask

    task automatic ld_word(input logic [31:0] v);
        bus_if.DEC = v;
        bus_if.ld  = 1'b1;
        step();
        bus_if.ld  = 1'b0;
    endtask

    task automatic check_scan(input string tag, input logic [6:0] exp_seg [8]);
        logic [7:0] e_an;
        for (int d = 0; d < 8; d++) begin
            e_an = ~(8'b1 << d);
            goto(d, 0);
            chk({tag, "_guard_an"}, 32'(bus_if.AN), 32'hFF);
            chk({tag, "_guard_seg"}, 32'(bus_if.SEG), 32'h7F);
            goto(d, 1);
            chk({tag, "_an"}, 32'(bus_if.AN), 32'(e_an));
            chk({tag, "_seg"}, 32'(bus_if.SEG), 32'(exp_seg[d]));
            chk({tag, "_dp"}, 32'(bus_if.DP), (d == 2) ? 32'd0 : 32'd1);
            goto(d, 3);
            chk({tag, "_an_end"}, 32'(bus_if.AN), 32'(e_an));
        end
    endtask

    logic [6:0] t_12345 [8] = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] t_zero_b[8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] t_zero_n[8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    logic [6:0] t_a007  [8] = '{7'h78, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] t_nines [8] = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};

    initial begin
        rst_n           = 1'b0;
        bus_if.DEC      = 32'h0;
        bus_if.ld       = 1'b0;
        bus_if.blank_lz = 1'b0;

        // Reset
        repeat (3) step();
        chk("rst_an", 32'(bus_if.AN), 32'hFF);
        chk("rst_seg", 32'(bus_if.SEG), 32'h7F);
        chk("rst_dp", 32'(bus_if.DP), 32'd1);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("rel_guard_an", 32'(bus_if.AN), 32'hFF);
        step();
        chk("rel_d0_an", 32'(bus_if.AN), 32'hFE);
        chk("rel_d0_seg", 32'(bus_if.SEG), 32'h40);

        // Normal value with blanking
        bus_if.blank_lz = 1'b1;
        ld_word(32'h0001_2345);
        check_scan("v12345", t_12345);

        // Zero with and without blanking
        ld_word(32'h0);
        check_scan("zero_blk", t_zero_b);
        bus_if.blank_lz = 1'b0;
        check_scan("zero_noblk", t_zero_n);

        // Dash stops blanking
        bus_if.blank_lz = 1'b1;
        ld_word(32'h0000_A007);
        check_scan("a007", t_a007);

        // ld coincident with a tick
        goto(0, 2);
        bus_if.DEC = 32'h9999_9999;
        bus_if.ld  = 1'b1;
        step();
        bus_if.ld  = 1'b0;
        chk("tick_old_an", 32'(bus_if.AN), 32'hFE);
        chk("tick_old_seg", 32'(bus_if.SEG), 32'h78);
        step();
        chk("tick_guard_an", 32'(bus_if.AN), 32'hFF);
        step();
        chk("tick_new_an", 32'(bus_if.AN), 32'hFD);
        chk("tick_new_seg", 32'(bus_if.SEG), 32'h10);
        check_scan("nines", t_nines);

        // DEC changes while ld stays low
        for (int i = 0; i < 12; i++) begin
            bus_if.DEC = 32'h1357_9BDF * (i + 1);
            step();
            chk("hold_seg", 32'(bus_if.SEG), (((cyc - 1) % 4) == 0) ? 32'h7F : 32'h10);
        end

        // Asynchronous reset mid-slot
        goto(3, 1);
        chk("pre_arst_an", 32'(bus_if.AN), 32'hF7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(bus_if.AN), 32'hFF);
        chk("arst_seg", 32'(bus_if.SEG), 32'h7F);
        chk("arst_dp", 32'(bus_if.DP), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("rst2_guard_an", 32'(bus_if.AN), 32'hFF);
        step();
        chk("rst2_d0_an", 32'(bus_if.AN), 32'hFE);
        chk("rst2_d0_seg", 32'(bus_if.SEG), 32'h40);
        goto(1, 1);
        chk("rst2_d1_an", 32'(bus_if.AN), 32'hFD);
        chk("rst2_d1_seg", 32'(bus_if.SEG), 32'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dec8_scan_display.md
Name: dec8_scan_display

Overview:
- Downstream consumer of the 24-bit binary to 8-digit BCD converter.
- Latches the packed 32-bit BCD word on a load strobe and drives a multiplexed 8-digit common-anode 7-segment display.
- Provides leading-zero blanking, an anti-ghosting guard interval and an optional decimal point.
- Sits between the converter and the board display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥ GUARD+2.
- GUARD, 2, clk cycles at the start of each slot during which all anodes are forced off.
- DP_POS, 8, digit index 0..7 whose decimal point is lit; 8 means no decimal point.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- DEC  in  32  packed BCD {D8..D1}; digit i occupies nibble DEC[4i+3:4i], i=0 is least significant.
- ld  in  1  one-cycle strobe; the converter controller asserts it once conversion has finished.
- blank_lz  in  1  1 = blank leading zeros.
- AN  out  8  anode enables, active-low; AN[i] drives digit i.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler=0, ptr=0, disp=0, AN=8'hFF, SEG=7'h7F, DP=1. Held while rst_n=0.
- Reset release mid-scan restarts the scan from digit 0 with disp=0.
- Display register disp[31:0] loads DEC on any edge where ld=1, otherwise holds. DEC is ignored while ld=0, so intermediate converter values never appear.
- Prescaler counts 0..SCAN_DIV-1 and wraps to 0. tick = (prescaler==SCAN_DIV-1).
- ptr (3 bits) increments on each tick and wraps 7→0.
- Outputs are registered. On each edge AN/SEG/DP are computed from the pre-edge values of prescaler, ptr, disp and blank_lz, giving a one-cycle output latency.
- A ld and a tick on the same edge are independent: both take effect, and the new digit shows new data one cycle later.
- Guard interval: when prescaler < GUARD, the next AN=8'hFF, SEG=7'h7F and DP=1.
- Otherwise AN = ~(8'b1 << ptr).
- Digit value n = disp[4*ptr+3 : 4*ptr]. Encoding:
  - 0→40, 1→79, 2→24, 3→30, 4→19
  - 5→12, 6→02, 7→78, 8→00, 9→10 (hex)
  - Any nibble ≥ A → 3F (dash, segment g only).
- Leading-zero blanking: digit ptr shows SEG=7'h7F (AN still enabled) when all of the following hold:
  - blank_lz=1,
  - ptr≠0,
  - every nibble from index 7 down to index ptr is 0.
- Digit 0 is never blanked, so value 0 displays "0".
- A dash nibble counts as non-zero and stops blanking.
- DP is 0 when outside the guard and ptr==DP_POS; otherwise 1. DP is not affected by zero blanking.
- Full scan period = 8·SCAN_DIV cycles.

Decomposition:
- Package dec8_disp_pkg holds:
  - segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F,
  - the ten digit patterns,
  - NDIG=8,
  - function bcd_to_seg(nibble) returning the active-low pattern.
- One combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out) wraps the function for standalone test.
- Scan, blanking and output registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with SCAN_DIV=4, GUARD=1 → during reset AN=FF, SEG=7F, DP=1; after release digit 0 shows SEG=40 with blank_lz=0.
- Load DEC=32'h00012345, blank_lz=1, SCAN_DIV=4, GUARD=1 → over one scan, digits 0..4 show 12,19,30,24,79 and digits 5..7 show AN active with SEG=7F. Each slot has exactly one guard cycle with AN=FF.
- Load DEC=0 with blank_lz=1 → digit 0 shows 40; digits 1..7 show 7F. With blank_lz=0, all 8 digits show 40.
- Load DEC=32'h0000A007, blank_lz=1 → digit 3 shows 3F, digits 1..2 show 40 (not blanked), digit 0 shows 78, digits 4..7 are blank.
- Assert ld with DEC=32'h99999999 on the same edge as a tick, DP_POS=2 → the next digit displays 10 one cycle after the edge, with no stale value. DP=0 only in slot 2.
- Change DEC every cycle with ld=0 → SEG never changes from the last loaded value. Asserting rst_n=0 asynchronously mid-slot forces AN=FF immediately, without waiting for a clock edge.
